// File: rtl/switch_led_pkg.sv
// Shared definitions for the switch-to-LED controller: LED drive modes.
package switch_led_pkg;

  // LED drive mode as presented on the MODE pins
  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_DIM    = 2'b11
  } mode_t;

  localparam int MODE_W = 2;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchroniser, consecutive-difference counter,
// debounced stable level and a one-cycle pulse when the stable level rises.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  logic             differ;
  logic             accept;

  // Bring the raw pin into the clock domain; nothing else looks at din
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign differ = sync_p1 ^ stable;
  // The last differing cycle of the run is the one that commits the new level
  assign accept = differ && (cnt == CNT_LAST);

  // Count consecutive cycles where the synced level disagrees with stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!differ || accept) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Commit the new level; the rise pulse is registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      rise <= accept & sync_p1;
      if (accept) begin
        stable <= sync_p1;
      end
    end
  end

  assign dout = stable;

endmodule

// File: rtl/switch_led_ctrl.sv
// Switch-to-LED controller: debounces WIDTH switches and drives WIDTH LEDs in
// pass, toggle-latch, blink or PWM-dim mode; exports debounced rise pulses.
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_DIV       = 50_000_000,
  parameter int PWM_BITS        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    SW,
  input  logic [MODE_W-1:0]   MODE,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic [WIDTH-1:0]    LED,
  output logic [WIDTH-1:0]    SW_EDGE
);

  localparam int                 BLINK_W    = $clog2(BLINK_DIV + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [WIDTH-1:0]    stable;
  logic [WIDTH-1:0]    rise;
  logic [WIDTH-1:0]    tog;
  logic [MODE_W-1:0]   mode_p0;
  mode_t               mode_p1;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic [WIDTH-1:0]    led_nxt;

  // Independent debouncer per channel
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (SW[i]),
      .dout (stable[i]),
      .rise (rise[i])
    );
  end

  // The rise pulses are already flops inside each debouncer
  assign SW_EDGE = rise;

  // Two-flop synchroniser for the mode pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_p0 <= '0;
      mode_p1 <= MODE_PASS;
    end else begin
      mode_p0 <= MODE;
      mode_p1 <= mode_t'(mode_p0);
    end
  end

  // Toggle latches follow debounced rises in every mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog <= '0;
    end else begin
      tog <= tog ^ rise;
    end
  end

  // Free-running blink divider; phase inverts each time the counter wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Free-running PWM counter wrapping at 2^PWM_BITS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // BRIGHT=0 never lights; BRIGHT=max lights all but one slot of the period
  assign pwm_on = (pwm_cnt < BRIGHT);

  // Select the LED pattern for the synced mode
  always_comb begin
    led_nxt = stable;
    case (mode_p1)
      MODE_PASS:   led_nxt = stable;
      MODE_TOGGLE: led_nxt = tog;
      MODE_BLINK:  led_nxt = stable & {WIDTH{phase}};
      MODE_DIM:    led_nxt = stable & {WIDTH{pwm_on}};
      default:     led_nxt = stable;
    endcase
  end

  // Output register so no input reaches the LED pins combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LED <= '0;
    end else begin
      LED <= led_nxt;
    end
  end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Scoreboard bench for switch_led_ctrl with a window-based reference model.
module tb_switch_led_ctrl;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int B  = 8;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  SW;
  logic [1:0]    MODE;
  logic [PB-1:0] BRIGHT;
  logic [W-1:0]  LED;
  logic [W-1:0]  SW_EDGE;

  int tests_run    = 0;
  int tests_failed = 0;

  switch_led_ctrl #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .BLINK_DIV(B), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .SW(SW), .MODE(MODE), .BRIGHT(BRIGHT),
    .LED(LED), .SW_EDGE(SW_EDGE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] led;
    logic [W-1:0] edg;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: input history since reset, plus derived levels
  logic [W-1:0] sw_hist[$];
  logic [1:0]   mode_hist[$];
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_tog    = '0;
  logic [W-1:0] m_rise   = '0;
  int           m_k      = 0;

  int           n;
  logic [W-1:0] acc, s_new, h, led_new;
  logic [1:0]   ms;
  logic         ph, pw;

  // Switch value sampled at clock edge idx (1 = first edge after reset)
  function automatic logic [W-1:0] sw_at(input int idx);
    if (idx < 1 || idx > sw_hist.size()) return '0;
    return sw_hist[idx-1];
  endfunction

  function automatic logic [1:0] mode_at(input int idx);
    if (idx < 1 || idx > mode_hist.size()) return 2'b00;
    return mode_hist[idx-1];
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Model: a bit accepts a new level once its synced value (SW two edges
  // late) has disagreed with the stable level for D edges in a row.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_hist.delete();
      mode_hist.delete();
      m_stable = '0;
      m_tog    = '0;
      m_rise   = '0;
      m_k      = 0;
      foreach (exp_q[i]) exp_q[i] = '0;
      if (clk) exp_q.push_back('0);
    end else begin
      n = m_k + 1;
      sw_hist.push_back(SW);
      mode_hist.push_back(MODE);
      acc = '1;
      for (int j = 2; j <= D + 1; j++) begin
        h = sw_at(n - j);
        acc = acc & (h ^ m_stable);
      end
      ms = mode_at(n - 2);
      ph = (((n - 1) / B) % 2) == 0;
      pw = ((n - 1) % (1 << PB)) < int'(BRIGHT);
      case (ms)
        2'b00:   led_new = m_stable;
        2'b01:   led_new = m_tog;
        2'b10:   led_new = ph ? m_stable : '0;
        default: led_new = pw ? m_stable : '0;
      endcase
      s_new    = m_stable ^ acc;
      m_tog    = m_tog ^ m_rise;
      m_rise   = acc & s_new;
      m_stable = s_new;
      m_k      = n;
      exp_q.push_back('{led: led_new, edg: m_rise});
    end
  end

  // Monitor: compare every registered output against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led", LED, e.led);
      check("sw_edge", SW_EDGE, e.edg);
    end
  end

  task automatic wait_cycles(input int cnt);
    repeat (cnt) @(posedge clk);
    #3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hold, r;
    SW = '0; MODE = 2'b00; BRIGHT = '0; rst = 1'b1;

    // Reset and PASS latency
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", LED, 4'b0000);
    check("rst_edge", SW_EDGE, 4'b0000);
    #2 rst = 1'b0;
    wait_cycles(4);
    SW = 4'b0101;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) check("lat_e5_edge", SW_EDGE, 4'b0000);
      if (e == 6) begin
        check("lat_e6_edge", SW_EDGE, 4'b0101);
        check("lat_e6_led", LED, 4'b0000);
      end
      if (e == 7) begin
        check("lat_e7_led", LED, 4'b0101);
        check("lat_e7_edge", SW_EDGE, 4'b0000);
      end
    end
    #2;

    // Bounce rejection then acceptance
    SW = 4'b0000;
    wait_cycles(12);
    for (int k = 0; k < 5; k++) begin
      SW = 4'b0001; wait_cycles(3);
      SW = 4'b0000; wait_cycles(3);
    end
    SW = 4'b0001; wait_cycles(10);
    SW = 4'b0000; wait_cycles(10);

    // Toggle latch, then PASS and back
    MODE = 2'b01; wait_cycles(4);
    for (int k = 0; k < 2; k++) begin
      SW = 4'b0100; wait_cycles(10);
      SW = 4'b0000; wait_cycles(10);
    end
    SW = 4'b0100; wait_cycles(10);
    MODE = 2'b00; wait_cycles(10);
    MODE = 2'b01; wait_cycles(10);
    SW = 4'b0000; wait_cycles(10);

    // Blink
    MODE = 2'b10; SW = 4'b1111; wait_cycles(40);
    SW = 4'b0000; wait_cycles(20);

    // PWM dim at three brightness levels
    MODE = 2'b11; SW = 4'b1111; BRIGHT = 4'd4; wait_cycles(48);
    BRIGHT = 4'd0;  wait_cycles(32);
    BRIGHT = 4'd15; wait_cycles(32);
    SW = 4'b0000; wait_cycles(12);

    // Async reset mid-operation: first drive the toggle latches to 1010
    MODE = 2'b01; wait_cycles(12);
    SW = m_tog ^ 4'b1010; wait_cycles(8);
    SW = 4'b0000; wait_cycles(10);
    check("tog_pre_reset", LED, 4'b1010);
    SW = 4'b0001; wait_cycles(4);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_led", LED, 4'b0000);
    check("arst_edge", SW_EDGE, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e <= 7) check("post_rst_led", LED, 4'b0000);
      if (e == 5) check("post_rst_e5_edge", SW_EDGE, 4'b0000);
      if (e == 6) check("post_rst_e6_edge", SW_EDGE, 4'b0001);
      if (e == 8) check("post_rst_e8_led", LED, 4'b0001);
    end
    #2;

    // Randomised traffic across modes, brightness and glitchy switches
    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 9);
      if (r < 2) MODE = 2'($urandom_range(0, 3));
      if (r == 2) BRIGHT = 4'($urandom_range(0, 15));
      SW = SW ^ 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 10);
      wait_cycles(hold);
    end
    wait_cycles(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
